// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and helpers for the memory self-test sequencer.
//   bist_state_e : sequencer states (IDLE, WR, RD, DRAIN, DONE)
//   MEM_*        : geometry of the 32x8 synchronous memory under test
//   pattern()    : expected word for an address, optionally inverted
package mem_bist_pkg;

  localparam int unsigned MEM_DEPTH = 32;
  localparam int unsigned MEM_AW    = 5;
  localparam int unsigned MEM_DW    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  // Computed at 32 bits so callers of any width up to 32 can truncate; truncation of the sum
  // gives the required modulo-2**DW wrap.
  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] addr,
                                          input logic inv);
    logic [31:0] sum;
    sum = seed + addr;
    return inv ? ~sum : sum;
  endfunction

endpackage

// File: rtl/mem_bist_cmp_pipe.sv
// mem_bist_cmp_pipe: RD_LAT-deep expected-data/valid shift register aligned to the memory read
// latency, plus the final compare against the returned read data.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, flushes all valid bits
//   push_i     : a read is issued this cycle
//   exp_i      : expected word for the issued read
//   rdata_i    : memory data_out
//   mismatch_o : one-cycle pulse when a valid pipe output disagrees with rdata_i
module mem_bist_cmp_pipe #(
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] exp_i,
  input  logic [DW-1:0] rdata_i,
  output logic          mismatch_o
);

  logic [RD_LAT-1:0]         vld_q, vld_d;
  logic [RD_LAT-1:0][DW-1:0] exp_q, exp_d;

  always_comb begin
    vld_d    = vld_q;
    exp_d    = exp_q;
    vld_d[0] = push_i;
    exp_d[0] = exp_i;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      exp_q <= '0;
    end else begin
      vld_q <= vld_d;
      exp_q <= exp_d;
    end
  end

  // Stage RD_LAT-1 lines up with the data_out produced for the read pushed RD_LAT cycles ago.
  assign mismatch_o = vld_q[RD_LAT-1] && (rdata_i != exp_q[RD_LAT-1]);

endmodule

// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: self-test sequencer for a synchronous single-port memory. On an accepted start
// it writes seed+addr to every location, reads all of them back, compares each word and
// reports a saturating error count and a pass flag.
// Optional build macro MEM_BIST_INV_PASS_EN adds a second write/read pass with inverted data.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, seed       : run request (honoured only in IDLE) and pattern seed
//   busy, done, pass  : run in progress, one-cycle completion pulse, result (held)
//   err_cnt           : mismatches in the current or last run, saturating
//   read, write, addr : memory strobes and address
//   data_in, data_out : memory write data and read data
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned AW     = MEM_AW,
  parameter int unsigned DW     = MEM_DW,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CW     = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic          read,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_in,
  input  logic [DW-1:0] data_out
);

  localparam logic [2:0] StIdle  = 3'(IDLE);
  localparam logic [2:0] StWr    = 3'(WR);
  localparam logic [2:0] StRd    = 3'(RD);
  localparam logic [2:0] StDrain = 3'(DRAIN);
  localparam logic [2:0] StDone  = 3'(DONE);

  localparam logic [2:0] DrainLast = 3'(RD_LAT - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    drain_q, drain_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [CW-1:0] err_q, err_d;
  logic          pass_q, pass_d;
  logic          inv;
  logic          push;
  logic          mismatch;
  logic [DW-1:0] exp_data;

`ifdef MEM_BIST_INV_PASS_EN
  logic inv_q, inv_d;
  assign inv = inv_q;
`else
  assign inv = 1'b0;
`endif

  // Same counter serves as write address in WR and read address in RD.
  assign exp_data = DW'(pattern(32'(seed_q), 32'(cnt_q), inv));
  assign push     = (state_q == StRd);

  mem_bist_cmp_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_cmp_pipe (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (push),
    .exp_i      (exp_data),
    .rdata_i    (data_out),
    .mismatch_o (mismatch)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    seed_d  = seed_q;
    pass_d  = pass_q;
    err_d   = err_q;
`ifdef MEM_BIST_INV_PASS_EN
    inv_d   = inv_q;
`endif

    if (mismatch && (err_q != {CW{1'b1}})) begin
      err_d = err_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = StWr;
`ifdef MEM_BIST_INV_PASS_EN
          inv_d   = 1'b0;
`endif
        end
      end
      StWr: begin
        if (&cnt_q) begin
          cnt_d   = '0;
          state_d = StRd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRd: begin
        if (&cnt_q) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
`ifdef MEM_BIST_INV_PASS_EN
          if (!inv_q) begin
            inv_d   = 1'b1;
            state_d = StWr;
          end else begin
            pass_d  = (err_d == '0);
            state_d = StDone;
          end
`else
          // err_d includes the final compare resolving in this cycle.
          pass_d  = (err_d == '0);
          state_d = StDone;
`endif
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

`ifdef MEM_BIST_INV_PASS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end
`endif

  always_comb begin
    read    = 1'b0;
    write   = 1'b0;
    addr    = '0;
    data_in = '0;
    if (state_q == StWr) begin
      write   = 1'b1;
      addr    = cnt_q;
      data_in = exp_data;
    end else if (state_q == StRd) begin
      read = 1'b1;
      addr = cnt_q;
    end
  end

  assign busy    = (state_q == StWr) || (state_q == StRd) || (state_q == StDrain);
  assign done    = (state_q == StDone);
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule
